// File: rtl/fetch_unit_pkg.sv
// Shared processor constants for the fetch stage: opcode field values and
// branch-history counter encoding, plus the saturating counter update rule.
package fetch_unit_pkg;

    localparam logic [3:0] OP_BRANCH = 4'b0010;
    localparam int unsigned CNT_BITS = 2;
    localparam logic [CNT_BITS-1:0] BHT_INIT = 2'b01;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = 2'b11;
    localparam logic [CNT_BITS-1:0] CNT_MIN  = 2'b00;

    function automatic logic [CNT_BITS-1:0] sat_update(
        input logic [CNT_BITS-1:0] cnt,
        input logic                taken
    );
        logic [CNT_BITS-1:0] nxt;
        nxt = cnt;
        if (taken && cnt != CNT_MAX) nxt = cnt + 1'b1;
        else if (!taken && cnt != CNT_MIN) nxt = cnt - 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_unit_branch_predictor.sv
// Table of 2-bit saturating counters; asynchronous lookup, single update port.
// Lookup reads the registered table, so a same-cycle update is not visible yet.
module branch_predictor
    import fetch_unit_pkg::*;
#(
    parameter int unsigned IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] lookupIdx_i,
    input  logic                updEn_i,
    input  logic [IDX_BITS-1:0] updIdx_i,
    input  logic                updTaken_i,
    output logic [CNT_BITS-1:0] counter_o
);

    localparam int unsigned ENTRIES = 2 ** IDX_BITS;

    logic [CNT_BITS-1:0] bht_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= BHT_INIT;
        end else if (updEn_i) begin
            bht_q[updIdx_i] <= sat_update(bht_q[updIdx_i], updTaken_i);
        end
    end

    assign counter_o = bht_q[lookupIdx_i];

endmodule

// File: rtl/fetch_unit_register.sv
// Generic register primitive with synchronous active-high reset and write enable.
module Register #(
    parameter int unsigned     BITS        = 32,
    parameter logic [BITS-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wrtEn_i,
    input  logic [BITS-1:0] dataIn_i,
    output logic [BITS-1:0] dataOut_o
);

    logic [BITS-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset)        data_q <= RESET_VALUE;
        else if (wrtEn_i) data_q <= dataIn_i;
    end

    assign dataOut_o = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and a BHT-based
// branch predictor. All outputs are combinational from the current PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      DBITS    = 32,
    parameter logic [DBITS-1:0] START_PC = 'h0000_0040,
    parameter int unsigned      BHT_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [DBITS-1:0] redirectPc,
    input  logic             bhtUpdate,
    input  logic [DBITS-1:0] bhtUpdatePc,
    input  logic             bhtTaken,
    output logic [DBITS-1:0] imemAddr,
    input  logic [DBITS-1:0] imemData,
    output logic [DBITS-1:0] instWord,
    output logic [DBITS-1:0] pcIncremented,
    output logic [DBITS-1:0] brBaseOffset,
    output logic             prediction
);

    logic [DBITS-1:0]    pc_q, pc_d, pc_cur;
    logic [CNT_BITS-1:0] cnt;
    logic                is_branch;

    Register #(
        .BITS        (DBITS),
        .RESET_VALUE (START_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .wrtEn_i   (1'b1),
        .dataIn_i  (pc_d),
        .dataOut_o (pc_q)
    );

    branch_predictor #(
        .IDX_BITS (BHT_BITS)
    ) u_bp (
        .clk         (clk),
        .reset       (reset),
        .lookupIdx_i (pc_cur[BHT_BITS+1:2]),
        .updEn_i     (bhtUpdate),
        .updIdx_i    (bhtUpdatePc[BHT_BITS+1:2]),
        .updTaken_i  (bhtTaken),
        .counter_o   (cnt)
    );

    // While reset is held the outputs already reflect the reset PC, not
    // whatever the register held before the first reset edge.
    assign pc_cur        = reset ? START_PC : pc_q;
    assign imemAddr      = pc_cur;
    assign instWord      = imemData;
    assign pcIncremented = pc_cur + DBITS'(4);
    assign brBaseOffset  = pcIncremented
                         + {{(DBITS-18){instWord[15]}}, instWord[15:0], 2'b00};
    assign is_branch     = (instWord[31:28] == OP_BRANCH);
    assign prediction    = ~reset & is_branch & cnt[1];

    always_comb begin
        pc_d = pcIncremented;
        if (redirect)        pc_d = redirectPc;
        else if (stall)      pc_d = pc_cur;
        else if (prediction) pc_d = brBaseOffset;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a small combinational imem.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, bhtUpdate, bhtTaken;
    logic [31:0] redirectPc, bhtUpdatePc;
    logic [31:0] imemAddr, imemData, instWord, pcIncremented, brBaseOffset;
    logic        prediction;

    logic [31:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imemData = mem[imemAddr[9:2]];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirectPc    (redirectPc),
        .bhtUpdate     (bhtUpdate),
        .bhtUpdatePc   (bhtUpdatePc),
        .bhtTaken      (bhtTaken),
        .imemAddr      (imemAddr),
        .imemData      (imemData),
        .instWord      (instWord),
        .pcIncremented (pcIncremented),
        .brBaseOffset  (brBaseOffset),
        .prediction    (prediction)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; redirect = 0; redirectPc = 0;
        bhtUpdate = 0; bhtUpdatePc = 0; bhtTaken = 0;
        tick(); tick();
        n_checks++; if (imemAddr !== 32'h40) begin n_fail++; $display("FAIL rst_addr got=%h exp=%h", imemAddr, 32'h40); end
        n_checks++; if (pcIncremented !== 32'h44) begin n_fail++; $display("FAIL rst_pcinc got=%h exp=%h", pcIncremented, 32'h44); end
        n_checks++; if (prediction !== 1'b0) begin n_fail++; $display("FAIL rst_pred got=%b exp=0", prediction); end
        reset = 0;
        tick();
        n_checks++; if (imemAddr !== 32'h44) begin n_fail++; $display("FAIL rst_next got=%h exp=%h", imemAddr, 32'h44); end
    endtask

    task automatic test_predict();
        stall = 1; bhtUpdate = 1; bhtUpdatePc = 32'h48; bhtTaken = 1;
        tick(); tick();
        n_checks++; if (imemAddr !== 32'h44) begin n_fail++; $display("FAIL pred_stallhold got=%h exp=%h", imemAddr, 32'h44); end
        stall = 0; bhtUpdate = 0;
        tick();
        n_checks++; if (imemAddr !== 32'h48) begin n_fail++; $display("FAIL pred_addr got=%h exp=%h", imemAddr, 32'h48); end
        n_checks++; if (instWord !== 32'h2000_FFFE) begin n_fail++; $display("FAIL pred_inst got=%h exp=%h", instWord, 32'h2000_FFFE); end
        n_checks++; if (prediction !== 1'b1) begin n_fail++; $display("FAIL pred_taken got=%b exp=1", prediction); end
        n_checks++; if (pcIncremented !== 32'h4C) begin n_fail++; $display("FAIL pred_pcinc got=%h exp=%h", pcIncremented, 32'h4C); end
        n_checks++; if (brBaseOffset !== 32'h44) begin n_fail++; $display("FAIL pred_target got=%h exp=%h", brBaseOffset, 32'h44); end
        tick();
        n_checks++; if (imemAddr !== 32'h44) begin n_fail++; $display("FAIL pred_nextpc got=%h exp=%h", imemAddr, 32'h44); end
    endtask

    task automatic test_stall();
        redirect = 1; redirectPc = 32'h50;
        tick();
        redirect = 0; stall = 1;
        n_checks++; if (imemAddr !== 32'h50) begin n_fail++; $display("FAIL stall_redir got=%h exp=%h", imemAddr, 32'h50); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (imemAddr !== 32'h50) begin n_fail++; $display("FAIL stall_hold%0d got=%h exp=%h", i, imemAddr, 32'h50); end
        end
        redirect = 1; redirectPc = 32'h100;
        tick();
        n_checks++; if (imemAddr !== 32'h100) begin n_fail++; $display("FAIL stall_vs_redir got=%h exp=%h", imemAddr, 32'h100); end
        redirect = 0; stall = 0;
    endtask

    task automatic test_read_before_write();
        redirect = 1; redirectPc = 32'h4C;
        tick();
        redirect = 0;
        bhtUpdate = 1; bhtUpdatePc = 32'h4C; bhtTaken = 1;
        #1;
        n_checks++; if (prediction !== 1'b0) begin n_fail++; $display("FAIL rbw_same got=%b exp=0", prediction); end
        tick();
        bhtUpdate = 0;
        n_checks++; if (imemAddr !== 32'h50) begin n_fail++; $display("FAIL rbw_fallthru got=%h exp=%h", imemAddr, 32'h50); end
        redirect = 1; redirectPc = 32'h4C;
        tick();
        redirect = 0;
        #1;
        n_checks++; if (prediction !== 1'b1) begin n_fail++; $display("FAIL rbw_revisit got=%b exp=1", prediction); end
        n_checks++; if (brBaseOffset !== 32'h60) begin n_fail++; $display("FAIL rbw_target got=%h exp=%h", brBaseOffset, 32'h60); end
        tick();
        n_checks++; if (imemAddr !== 32'h60) begin n_fail++; $display("FAIL rbw_taken got=%h exp=%h", imemAddr, 32'h60); end
    endtask

    task automatic test_saturate();
        // from 01: T T T N N N N T T -> 10 11 11 10 01 00 00 01 10
        logic [8:0] tk;
        logic [8:0] ex;
        tk = 9'b1_1000_0111;
        ex = 9'b1_0000_1111;
        redirect = 1; redirectPc = 32'h60;
        tick();
        redirect = 0; stall = 1; bhtUpdate = 1; bhtUpdatePc = 32'h60;
        for (int i = 0; i < 9; i++) begin
            bhtTaken = tk[i];
            tick();
            n_checks++; if (prediction !== ex[i]) begin n_fail++; $display("FAIL sat_step%0d got=%b exp=%b", i, prediction, ex[i]); end
        end
        n_checks++; if (imemAddr !== 32'h60) begin n_fail++; $display("FAIL sat_hold got=%h exp=%h", imemAddr, 32'h60); end
        bhtUpdate = 0; stall = 0;
    endtask

    task automatic test_wrap();
        redirect = 1; redirectPc = 32'hFFFF_FFFC;
        tick();
        redirect = 0;
        n_checks++; if (pcIncremented !== 32'h0) begin n_fail++; $display("FAIL wrap_pcinc got=%h exp=%h", pcIncremented, 32'h0); end
        tick();
        n_checks++; if (imemAddr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got=%h exp=%h", imemAddr, 32'h0); end
        redirect = 1; redirectPc = 32'h41;
        tick();
        redirect = 0;
        n_checks++; if (pcIncremented !== 32'h45) begin n_fail++; $display("FAIL unalign_pcinc got=%h exp=%h", pcIncremented, 32'h45); end
        tick();
        n_checks++; if (imemAddr !== 32'h45) begin n_fail++; $display("FAIL unalign_next got=%h exp=%h", imemAddr, 32'h45); end
    endtask

    task automatic test_reset_mid();
        redirect = 1; redirectPc = 32'h50;
        tick();
        redirect = 0; stall = 1;
        tick(); tick();
        reset = 1; redirect = 1; redirectPc = 32'h200;
        bhtUpdate = 1; bhtUpdatePc = 32'h48; bhtTaken = 0;
        #1;
        n_checks++; if (imemAddr !== 32'h40) begin n_fail++; $display("FAIL rstmid_comb got=%h exp=%h", imemAddr, 32'h40); end
        tick();
        reset = 0; redirect = 0; stall = 0; bhtUpdate = 0;
        n_checks++; if (imemAddr !== 32'h40) begin n_fail++; $display("FAIL rstmid_pc got=%h exp=%h", imemAddr, 32'h40); end
        tick();
        n_checks++; if (imemAddr !== 32'h44) begin n_fail++; $display("FAIL rstmid_next got=%h exp=%h", imemAddr, 32'h44); end
        // Every entry must be 01: not predicted, and one taken update flips it.
        for (int i = 0; i < 16; i++) begin
            redirect = 1; redirectPc = 32'h80 + 32'(4 * i);
            tick();
            redirect = 0; stall = 1;
            #1;
            n_checks++; if (prediction !== 1'b0) begin n_fail++; $display("FAIL bht_init%0d got=%b exp=0", i, prediction); end
            bhtUpdate = 1; bhtUpdatePc = 32'h80 + 32'(4 * i); bhtTaken = 1;
            tick();
            bhtUpdate = 0;
            #1;
            n_checks++; if (prediction !== 1'b1) begin n_fail++; $display("FAIL bht_weak%0d got=%b exp=1", i, prediction); end
        end
        stall = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h48 >> 2] = 32'h2000_FFFE;
        mem[8'h4C >> 2] = 32'h2000_0004;
        mem[8'h60 >> 2] = 32'h2000_0000;
        for (int i = 0; i < 16; i++) mem[32 + i] = 32'h2000_0000;

        test_reset();
        test_predict();
        test_stall();
        test_read_before_write();
        test_saturate();
        test_wrap();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DBITS, default 32, datapath width.
REQ-002 SHALL have parameter START_PC, default 32'h0000_0040, PC value after reset.
REQ-003 SHALL have parameter BHT_BITS, default 4, log2 of branch-history-table entries.
REQ-004 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC and predictor lookup; driven with the inverse of the IF pipeline register write enable.
- redirect  in  1  mispredict/jump correction from a later stage.
- redirectPc  in  DBITS  corrected fetch address.
- bhtUpdate  in  1  train predictor this cycle.
- bhtUpdatePc  in  DBITS  PC of the resolved branch.
- bhtTaken  in  1  resolved branch outcome.
- imemAddr  out  DBITS  instruction memory address (= PC).
- imemData  in  DBITS  instruction word; combinational read of imemAddr.
- instWord  out  DBITS  = imemData.
- pcIncremented  out  DBITS  PC + 4.
- brBaseOffset  out  DBITS  pcIncremented + (sign-extended instWord[15:0] << 2).
- prediction  out  1  predicted-taken flag for the current instruction.

Function
REQ-005 SHALL hold a PC register; imemAddr SHALL equal PC.
REQ-006 SHALL compute instWord, pcIncremented, brBaseOffset and prediction combinationally from PC and imemData, for capture by the IF pipeline register on the same edge (zero internal latency).
REQ-007 SHALL treat an instruction as a branch when instWord[31:28] == OP_BRANCH.
REQ-008 SHALL hold a BHT of 2**BHT_BITS 2-bit saturating counters, indexed by PC[BHT_BITS+1:2].
REQ-009 SHALL drive prediction = isBranch AND counter[1] of the entry indexed by PC.
REQ-010 SHALL select next PC with priority:
- redirect: redirectPc;
- stall: PC unchanged;
- prediction: brBaseOffset;
- otherwise: pcIncremented.
REQ-011 SHALL give redirect priority over stall when both are asserted in the same cycle.
REQ-012 SHALL, when bhtUpdate=1, change the entry indexed by bhtUpdatePc[BHT_BITS+1:2] as follows:
- bhtTaken=1: increment, saturating at 2'b11;
- bhtTaken=0: decrement, saturating at 2'b00.
REQ-013 SHALL perform BHT training independent of stall and redirect.
REQ-014 SHALL make a lookup and an update of the same entry in the same cycle return the pre-update value (read-before-write).
REQ-015 SHALL compute all PC arithmetic modulo 2**DBITS, wrapping silently with no overflow flag.
REQ-016 SHALL not check alignment; PC[1:0] propagates unchanged.

Reset
REQ-017 SHALL, on a clk edge with reset=1, set PC to START_PC and all BHT entries to 2'b01 (weakly not-taken).
REQ-018 SHALL give reset priority over redirect, stall and bhtUpdate.
REQ-019 SHALL, during reset, drive outputs as combinational functions of the reset PC: imemAddr=START_PC, pcIncremented=START_PC+4, prediction=0.

Structure
REQ-020 SHALL take OP_BRANCH (4'b0010), the BHT reset value (2'b01) and counter-width constants from the shared processor constants package.
REQ-021 SHALL implement the predictor as one sub-module, branch_predictor: lookup index in, update port in, counter out.
REQ-022 SHALL build the PC register from the existing Register primitive.

Verification
REQ-023 Reset with START_PC=0x40 -> imemAddr=0x40, pcIncremented=0x44, prediction=0; next edge with no control inputs -> PC=0x44.
REQ-024 Branch at 0x48 with imm=0xFFFE, BHT entry 2 trained twice taken -> prediction=1, brBaseOffset=0x44, next PC=0x44.
REQ-025 stall=1 for 3 cycles at PC=0x50 -> PC holds 0x50; stall=1 with redirect=1, redirectPc=0x100 -> next PC=0x100.
REQ-026 Counter at 2'b11 with bhtTaken=1 -> stays 2'b11; at 2'b00 with bhtTaken=0 -> stays 2'b00; three not-taken updates from 2'b11 -> 2'b00.
REQ-027 Same-cycle lookup and update of index 3 (counter 2'b01, bhtTaken=1) -> prediction=0 this cycle, prediction=1 on the next visit.
REQ-028 PC=0xFFFF_FFFC -> pcIncremented=0x0; reset asserted mid-stall with a pending redirect -> PC=START_PC and all BHT entries=2'b01.
